// File: rtl/sound_write_sequencer_pkg.sv
// Shared types and default strobe timing for the sound-chip write sequencer.
// Sound_Generator benches import this package to pick up the strobe timing.
package sound_write_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } sws_state_e;

    localparam int SWS_DEPTH      = 4;
    localparam int SWS_WE_CYCLES  = 8;
    localparam int SWS_GAP_CYCLES = 2;

    function automatic int sws_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sound_write_sequencer_if.sv
// Push side (valid/ready byte requests) plus the DATA/nWE slow-bus outputs.
interface sound_write_sequencer_if;
    logic       req_valid;
    logic [7:0] req_data;
    logic       req_ready;
    logic       busy;
    logic [7:0] DATA;
    logic       nWE;

    modport master (
        output req_valid, req_data,
        input  req_ready, busy, DATA, nWE
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, busy, DATA, nWE
    );
endinterface

// File: rtl/sound_write_sequencer_byte_fifo.sv
// DEPTH x 8 synchronous FIFO; full/empty derived from the extra pointer bit.
module sound_write_sequencer_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [DEPTH];
    logic        w_push;
    logic        w_pop;

    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/sound_write_sequencer.sv
// Replays queued command bytes onto DATA with a timed active-low nWE strobe,
// advancing bus timing only on clk_en.
module sound_write_sequencer
    import sound_write_sequencer_pkg::*;
#(
    parameter int DEPTH      = SWS_DEPTH,
    parameter int WE_CYCLES  = SWS_WE_CYCLES,
    parameter int GAP_CYCLES = SWS_GAP_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    sound_write_sequencer_if.slave       bus
);
    localparam int CW = $clog2(sws_max(WE_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [CW-1:0] WE_LAST  = CW'(WE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    sws_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_data;
    logic          r_nwe;

    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;
    logic       w_push;
    logic       w_pop;

    assign w_push = bus.req_valid && !w_full;
    // A pop happens exactly when the FSM leaves IDLE or HOLD with work queued.
    assign w_pop  = clk_en && !w_empty &&
                    ((r_state == ST_IDLE) ||
                     ((r_state == ST_HOLD) && (r_cnt == GAP_LAST)));

    sound_write_sequencer_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (bus.req_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.req_ready = !w_full;
    assign bus.busy      = !w_empty || (r_state != ST_IDLE);
    assign bus.DATA      = r_data;
    assign bus.nWE       = r_nwe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_data  <= 8'h00;
            r_nwe   <= 1'b1;
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    r_nwe <= 1'b1;
                    if (w_pop) begin
                        r_data  <= w_head;
                        r_cnt   <= '0;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_nwe   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (r_cnt == WE_LAST) begin
                        r_nwe   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (w_pop) begin
                            r_data  <= w_head;
                            r_state <= ST_SETUP;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_nwe   <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
